// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate feeding a registered sigmoid ROM.
// Accumulates N_INPUTS x*w beats on a bias, quantises to a ROM address, returns y.
module neuron_mac #(
    parameter int N_INPUTS   = 16,
    parameter int IN_WIDTH   = 8,
    parameter int W_WIDTH    = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int SHIFT      = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   in_x,
    input  logic [W_WIDTH-1:0]    in_w,
    input  logic [ACC_WIDTH-1:0]  bias,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_y
);

    localparam int P  = IN_WIDTH + W_WIDTH;
    localparam int CW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_INPUTS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SMAX =
        ACC_WIDTH'((2 ** (ADDR_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SMIN =
        -ACC_WIDTH'(2 ** (ADDR_WIDTH - 1));

    typedef enum logic [2:0] {
        ACC,
        QUANT,
        WAIT,
        CAPT,
        OUT
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]                count;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [P-1:0]          xe, we, prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext, base, s, sat;
    logic                         beat;

    assign in_ready = (state_q == ACC);
    assign beat     = in_valid && in_ready;

    // x is unsigned, so zero-extend before the signed multiply
    assign xe       = {{(P - IN_WIDTH){1'b0}}, in_x};
    assign we       = {{(P - W_WIDTH){in_w[W_WIDTH-1]}}, in_w};
    assign prod     = xe * we;
    assign prod_ext = {{(ACC_WIDTH - P){prod[P-1]}}, prod};
    assign base     = (count == '0) ? $signed(bias) : acc;

    assign s = acc >>> SHIFT;

    always_comb begin
        sat = s;
        if (s > SMAX) begin
            sat = SMAX;
        end else if (s < SMIN) begin
            sat = SMIN;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACC: begin
                if (beat && count == LAST) begin
                    state_d = QUANT;
                end
            end
            QUANT: state_d = WAIT;
            WAIT:  state_d = CAPT;
            CAPT:  state_d = OUT;
            OUT: begin
                if (out_ready) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            acc       <= '0;
            rom_addr  <= '0;
            out_y     <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state_q)
                ACC: begin
                    if (beat) begin
                        acc   <= base + prod_ext;
                        count <= (count == LAST) ? '0 : count + 1'b1;
                    end
                end
                QUANT: begin
                    // offset binary: two's complement with the MSB flipped
                    rom_addr <= {~sat[ADDR_WIDTH-1], sat[ADDR_WIDTH-2:0]};
                end
                WAIT: begin
                end
                CAPT: begin
                    out_y     <= rom_data;
                    out_valid <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboarded directed bench for neuron_mac with a registered ROM model.
`timescale 1ns/1ps
module tb_neuron_mac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_x;
    logic [7:0]  in_w;
    logic [23:0] bias;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_y;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_acc_cyc = 0;

    typedef struct {
        int addr;
        int y;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: mem[a] = a[11:4], one-cycle registered read
    always @(posedge clk) rom_data <= rom_addr[11:4];

    neuron_mac #(
        .N_INPUTS(4), .IN_WIDTH(8), .W_WIDTH(8), .ACC_WIDTH(24),
        .SHIFT(4), .ADDR_WIDTH(12), .DATA_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_w(in_w), .bias(bias),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // monitor: pops on every output handshake
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_y", int'(out_y), e.y);
                chk("rom_addr_at_out", int'(rom_addr), e.addr);
            end
        end
    end

    // called at a negedge, returns at a negedge after acceptance
    task automatic beat(input int x, input int w, input int b);
        int t;
        in_x = 8'(x);
        in_w = 8'(w);
        bias = 24'(b);
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("beat_timeout", 0, 1);
        @(posedge clk);
        last_acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic eval4(input int x, input int w, input int b,
                         input int ea, input int ey);
        exp_t e;
        e.addr = ea;
        e.y = ey;
        sb.push_back(e);
        for (int i = 0; i < 4; i++) beat(x, w, b);
    endtask

    task automatic wait_out();
        int t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int y0;
        int c1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_x = '0;
        in_w = '0;
        bias = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_out_y", int'(out_y), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);

        // basic, with latency checks
        eval4(16, 1, 0, 2052, 128);
        chk("lat_addr_t0", int'(rom_addr), 0);
        @(negedge clk);
        chk("lat_addr_t1", int'(rom_addr), 2052);
        chk("lat_in_ready_quant", int'(in_ready), 0);
        @(negedge clk);
        chk("lat_valid_t2", int'(out_valid), 0);
        @(negedge clk);
        chk("lat_valid_t3", int'(out_valid), 1);
        drain();

        // positive saturation
        eval4(255, 127, 0, 4095, 255);
        drain();

        // negative saturation
        eval4(255, -128, 0, 0, 0);
        drain();

        // floor rounding of -1
        eval4(0, 5, -1, 2047, 127);
        drain();

        // bubbles on in_valid, then output stall
        out_ready = 1'b0;
        sb.push_back('{addr: 2052, y: 128});
        for (int i = 0; i < 4; i++) begin
            beat(16, 1, 0);
            @(negedge clk);
        end
        wait_out();
        y0 = int'(out_y);
        chk("stall_y_value", y0, 128);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_x = 8'd99;
            in_w = 8'd99;
            @(negedge clk);
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_y", int'(out_y), y0);
            chk("stall_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // reset mid-evaluation
        beat(50, 50, 1000);
        beat(50, 50, 1000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_rom_addr", int'(rom_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        eval4(0, 7, 32, 2050, 128);
        drain();

        // back-to-back with out_ready tied high
        sb.push_back('{addr: 2046, y: 127});
        for (int i = 0; i < 4; i++) beat(10, -3, 100);
        c1 = last_acc_cyc;
        sb.push_back('{addr: 2106, y: 131});
        beat(200, 5, -50);
        chk("b2b_gap", last_acc_cyc - c1, 5);
        beat(1, 1, 0);
        beat(3, -7, 0);
        beat(0, 9, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
